// File: rtl/nanci_result_drain.sv
// ---------------------------------------------------------------------------
// nanci_result_drain
//
// Drain stage behind the right boundary column of the Nanci PE mesh. After
// the compute phase the mesh shifts its contents out one column per clock.
// This block captures SQRT_N columns of SQRT_N words each into a local buffer.
// It then streams the buffer out in row-major order over a valid/ready
// interface, one word per transfer, and skips MAX_INT padding words.
//
// The mesh cannot be stalled, so capture is unconditional and the buffer
// holds a whole mesh.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset
//   i_start  : pulse, column 0 is present on i_col in this cycle
//   i_col    : boundary column, row r at bits [(r+1)*W-1 : r*W]
//   o_data   : output word (registered)
//   o_valid  : o_data valid (registered)
//   i_ready  : consumer accepts o_data when o_valid && i_ready
//   o_busy   : high in CAPTURE, EMIT and DONE
//   o_done   : one-cycle pulse after the last word has been accepted
//   o_count  : words accepted since the last accepted i_start
// ---------------------------------------------------------------------------
module nanci_result_drain #(
    parameter int N          = 16,
    parameter int SQRT_N     = 4,
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 3,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      i_start,
    input  logic [SQRT_N*(ADDR_WIDTH+DATA_WIDTH)-1:0] i_col,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0]          o_data,
    output logic                                      o_valid,
    input  logic                                      i_ready,
    output logic                                      o_busy,
    output logic                                      o_done,
    output logic [$clog2(N):0]                        o_count
);

    localparam int W     = ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W = $clog2(N) + 1;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int COL_W = (SQRT_N > 1) ? $clog2(SQRT_N) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EMIT    = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Padding is detected over the whole word; the address/data split has
    // no meaning inside this block.
    function automatic logic is_pad(input logic [W-1:0] word);
        return word == MAX_INT;
    endfunction

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [W-1:0]       data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Capture buffer, row-major: entry r*SQRT_N + c holds row r of column c.
    logic [W-1:0]       buf_q [N];

    logic               cap_en;
    logic [COL_W-1:0]   cap_col;
    logic               out_free;
    logic               out_accept;
    logic [IDX_W-1:0]   ptr_idx;
    logic [W-1:0]       entry;

    assign out_free   = !valid_q || i_ready;
    assign out_accept = valid_q && i_ready;
    assign ptr_idx    = ptr_q[IDX_W-1:0];
    // Only looked at while ptr_q < N, so the index is always in range then.
    assign entry      = buf_q[ptr_idx];

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cap_en  = 1'b0;
        cap_col = col_q;

        if (out_accept) begin
            count_d = count_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    cap_en  = 1'b1;
                    cap_col = '0;
                    count_d = '0;
                    col_d   = COL_W'(1);
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                    // A single-row mesh is fully captured by the start edge.
                    state_d = (SQRT_N == 1) ? EMIT : CAPTURE;
                end
            end

            CAPTURE: begin
                cap_en  = 1'b1;
                cap_col = col_q;
                col_d   = col_q + 1'b1;
                if (col_q == COL_W'(SQRT_N - 1)) begin
                    ptr_d   = '0;
                    state_d = EMIT;
                end
            end

            EMIT: begin
                // The output register only advances when it is empty or is
                // being drained this edge, which keeps i_ready out of any
                // combinational path to o_valid/o_data.
                if (out_free) begin
                    if (ptr_q < CNT_W'(N)) begin
                        if (is_pad(entry)) begin
                            valid_d = 1'b0;
                        end else begin
                            data_d  = entry;
                            valid_d = 1'b1;
                        end
                        ptr_d = ptr_q + 1'b1;
                    end else begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                busy_d  = 1'b0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            ptr_q   <= '0;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Buffer contents carry no state worth resetting; every entry is
    // rewritten by the capture that precedes any read.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            for (int r = 0; r < SQRT_N; r++) begin
                buf_q[IDX_W'(r * SQRT_N) + IDX_W'(cap_col)] <= i_col[r*W +: W];
            end
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_count = count_q;

endmodule

// File: tb/tb_nanci_result_drain.sv
module tb_nanci_result_drain;

    localparam int SQRT_N = 2;
    localparam int N      = 4;
    localparam int AW     = 3;
    localparam int DW     = 3;
    localparam int W      = AW + DW;
    localparam int CW     = SQRT_N * W;
    localparam logic [W-1:0] PAD = 6'b111111;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [CW-1:0] i_col;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          i_ready;
    logic          o_busy;
    logic          o_done;
    logic [2:0]    o_count;

    nanci_result_drain #(
        .N          (N),
        .SQRT_N     (SQRT_N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (i_start),
        .i_col   (i_col),
        .o_data  (o_data),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_count (o_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: samples on the falling edge. A word shown with i_ready high is
    // taken at the next rising edge and is compared against the scoreboard.
    // A word shown with i_ready low must still be there, unchanged, one
    // cycle later.
    logic         hold_pend = 1'b0;
    logic [W-1:0] hold_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                chk("hold_valid", int'(o_valid), 1);
                chk("hold_data", int'(o_data), int'(hold_data));
            end
            hold_pend = 1'b0;
            if (o_valid) begin
                chk("no_pad_out", int'(o_data == PAD), 0);
            end
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_word: got %0d, expected no word", o_data);
                end else begin
                    chk("word", int'(o_data), int'(exp_q.pop_front()));
                end
            end else if (o_valid) begin
                hold_pend = 1'b1;
                hold_data = o_data;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Row-major expected stream, padding dropped.
    task automatic push_words(input logic [CW-1:0] c0, input logic [CW-1:0] c1);
        logic [W-1:0] w;
        for (int r = 0; r < SQRT_N; r++) begin
            for (int c = 0; c < SQRT_N; c++) begin
                w = (c == 0) ? c0[r*W +: W] : c1[r*W +: W];
                if (w != PAD) exp_q.push_back(w);
            end
        end
    endtask

    // Leaves the bench just after the second capture edge.
    task automatic start_burst(input string tag, input logic [CW-1:0] c0,
                               input logic [CW-1:0] c1);
        i_start = 1'b1;
        i_col   = c0;
        tick();
        i_start = 1'b0;
        i_col   = c1;
        chk({tag, "_busy_cap"}, int'(o_busy), 1);
        chk({tag, "_valid_cap0"}, int'(o_valid), 0);
        tick();
        i_col = CW'($urandom);
        chk({tag, "_valid_cap1"}, int'(o_valid), 0);
    endtask

    task automatic run_burst(input string tag, input logic [CW-1:0] c0,
                             input logic [CW-1:0] c1, input int stall,
                             input int stall_word, input bit pulse_emit,
                             input bit pulse_done, input int exp_count,
                             input int exp_tdone, input int exp_nvalid,
                             input int exp_first);
        int t_done = -1;
        int n_valid = 0;
        int seen = 0;
        push_words(c0, c1);
        i_ready = (stall == 0);
        start_burst(tag, c0, c1);
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 1) chk({tag, "_first_valid"}, int'(o_valid), exp_first);
            if (pulse_emit && t == 2) begin
                i_start = 1'b1;
                i_col   = CW'($urandom);
            end else begin
                i_start = 1'b0;
            end
            if (o_valid) n_valid++;
            if (o_valid && stall > 0) begin
                if (seen < stall) begin
                    seen++;
                    i_ready = 1'b0;
                    chk({tag, "_stall_data"}, int'(o_data), stall_word);
                end else begin
                    i_ready = 1'b1;
                end
            end
            if (o_done) begin
                t_done = t;
                break;
            end
        end
        chk({tag, "_done_cycle"}, t_done, exp_tdone);
        chk({tag, "_nvalid"}, n_valid, exp_nvalid);
        chk({tag, "_count"}, int'(o_count), exp_count);
        chk({tag, "_busy_done"}, int'(o_busy), 1);
        i_start = pulse_done;
        tick();
        i_start = 1'b0;
        chk({tag, "_done_clear"}, int'(o_done), 0);
        chk({tag, "_busy_idle"}, int'(o_busy), 0);
        chk({tag, "_count_hold"}, int'(o_count), exp_count);
        chk({tag, "_all_words"}, exp_q.size(), 0);
        i_ready = 1'b1;
        tick();
    endtask

    localparam logic [CW-1:0] T2_C0 = {6'b001010, 6'b000101};
    localparam logic [CW-1:0] T2_C1 = {6'b011111, 6'b010001};
    localparam logic [CW-1:0] T3_C1 = {6'b011111, 6'b111111};
    localparam logic [CW-1:0] ALL_P = {6'b111111, 6'b111111};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_ready = 1'b1;
        i_col   = '0;

        // 1: reset state and idle quietness
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_done", int'(o_done), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_data", int'(o_data), 0);
        for (int i = 0; i < 4; i++) begin
            i_col = CW'($urandom);
            tick();
            chk("idle_valid", int'(o_valid), 0);
            chk("idle_busy", int'(o_busy), 0);
        end

        // 2: basic stream, words 5,17,10,31 on consecutive cycles
        run_burst("t2", T2_C0, T2_C1, 0, 0, 1'b0, 1'b0, 4, 5, 4, 1);

        // 3: one padding entry -> one bubble, three words
        run_burst("t3", T2_C0, T3_C1, 0, 0, 1'b0, 1'b0, 3, 5, 3, 1);

        // 4: backpressure on the first three valid cycles
        run_burst("t4", T2_C0, T2_C1, 3, 5, 1'b0, 1'b0, 4, 8, 7, 1);

        // 5: all padding
        run_burst("t5", ALL_P, ALL_P, 0, 0, 1'b0, 1'b0, 0, 5, 0, 0);

        // 6a: i_start during EMIT and during DONE is ignored
        run_burst("t6a", T2_C0, T2_C1, 0, 0, 1'b1, 1'b1, 4, 5, 4, 1);

        // 6b: reset after two accepted words
        i_ready = 1'b1;
        push_words(T2_C0, T2_C1);
        start_burst("t6b", T2_C0, T2_C1);
        tick();
        tick();
        tick();
        chk("t6b_count_mid", int'(o_count), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        chk("t6b_valid", int'(o_valid), 0);
        chk("t6b_busy", int'(o_busy), 0);
        chk("t6b_count", int'(o_count), 0);
        chk("t6b_done", int'(o_done), 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("t6b_quiet_valid", int'(o_valid), 0);
            chk("t6b_quiet_done", int'(o_done), 0);
        end

        // 6c: fresh burst after the reset
        run_burst("t6c", T2_C0, T2_C1, 0, 0, 1'b0, 1'b0, 4, 5, 4, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
